md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
Parametrised multiply/divide unit with HI/LO registers. It is the next-generation arithmetic block for the pipelined CPU and sits in the EX stage beside the ALU. It handles mult/multu/div/divu with a configurable multi-cycle busy window, and mthi/mtlo as single-cycle writes. It exports busy/stall information so the hazard unit can hold mfhi/mflo and further MD instructions.

Parameters:
WIDTH, 32, operand and HI/LO width in bits.
MULT_CYCLES, 5, busy cycles for mult/multu (must be at least 1).
DIV_CYCLES, 10, busy cycles for div/divu (must be at least 1).
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  issue strobe, sampled at posedge
md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved (no-op)
srcA  input  WIDTH  rs value (dividend / multiplicand / MT source)
srcB  input  WIDTH  rt value (divisor / multiplier)
busy  output  1  registered; operation in flight
stall_req  output  1  combinational: busy OR (start AND md_op<=3)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
cancel  input  1  present only with MDU_CANCEL_EN

Behaviour:
- Reset asserted (reset==0) sets, asynchronously: hi=0, lo=0, busy=0, counter=0, state IDLE. Pending results are discarded, including when reset arrives mid-operation.
- States: IDLE and BUSY.
- In IDLE with start and op 0-3 at edge t:
  - Capture the full-width result into the internal regs res_hi/res_lo.
  - Load counter = N-1, where N is MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy=1 after edge t.
- In BUSY: the counter decrements each edge. At the edge where counter==0:
  - hi<=res_hi, lo<=res_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles.
  - New HI/LO become visible in the same cycle busy falls.
- hi/lo hold their old values during BUSY; mfhi/mflo are stalled via stall_req.
- MTHI/MTLO in IDLE: hi<=srcA (or lo<=srcA) at the sampled edge. They never assert busy.
- Any start while BUSY is ignored entirely. HI/LO and the counter are unaffected; the hazard unit must prevent it. Reserved ops are ignored.
- MULT: signed 2*WIDTH product; HI=upper half, LO=lower half. MULTU: same, unsigned.
- DIV: quotient truncates toward zero and goes to LO; remainder takes the sign of the dividend and goes to HI.
  - Overflow case min_int / -1: LO=min_int, HI=0.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (srcB==0) for DIV/DIVU: the unit still goes busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- Results are computed with behavioural * and / on captured operands. No iterative algorithm is required; only the latency is contractual.

Optional Feature:
MDU_CANCEL_EN:
- Defined: adds the cancel input, used for exception flush.
  - cancel high at an edge while BUSY returns the unit to IDLE, busy<=0, and HI/LO are untouched.
  - cancel has priority over completion in the same cycle.
  - cancel together with start in IDLE suppresses the start, including MTHI/MTLO.
- Undefined: no cancel port exists; an operation always runs to completion.

Decomposition:
- Shared package md_pkg:
  - md_op encodings (MD_MULT..MD_MTLO);
  - state encodings IDLE/BUSY;
  - default cycle counts.
- One natural sub-module: md_calc, combinational. It takes op, srcA and srcB and returns res_hi, res_lo and div_zero, covering the signed/unsigned and division-edge rules.
- The counter, FSM and HI/LO registers stay in md_unit.

Test Plan:
- Reset mid-operation: MULT issued, then reset pulled low at cycle 2 → hi=lo=0 and busy=0 immediately; the unit accepts a new start after reset is released.
- MULT 0xFFFFFFFF×0x00000002 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9(-7)/0x00000002 → busy high 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 7/0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO → busy 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MULT in flight, then MTLO 0x5 and DIVU started at cycle 2 → both ignored; the MULT result lands at cycle 5. Check stall_req=1 throughout and stall_req=1 combinationally on the start cycle.
- With MDU_CANCEL_EN: DIV started, cancel at cycle 4 → busy=0 next edge, HI/LO unchanged. Cancel coincident with the final cycle also leaves HI/LO unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// Used by md_calc and md_unit. MDU_CANCEL_EN is handled in md_unit.
package md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;
   localparam int DEF_CNT_W       = 4;

   // Ops 0-3 occupy the unit for several cycles; 4-7 never do.
   function automatic logic is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide result generator.
// Applies the signed/unsigned rules and the divide-by-zero and min_int/-1 cases.
module md_calc
   import md_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_res_hi,
   output logic [WIDTH-1:0] o_res_lo,
   output logic             o_div_zero
);

   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic signed [2*WIDTH-1:0] w_prod_s;
   logic        [2*WIDTH-1:0] w_prod_u;
   logic                      w_b_zero;
   logic                      w_ovf;
   logic        [WIDTH-1:0]   w_div_s;
   logic        [WIDTH-1:0]   w_div_u;
   logic signed [WIDTH-1:0]   w_quot_s;
   logic signed [WIDTH-1:0]   w_rem_s;
   logic        [WIDTH-1:0]   w_quot_u;
   logic        [WIDTH-1:0]   w_rem_u;

   assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
   assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

   // Dividing min_int by 1 yields exactly the overflow answer (LO=min_int, HI=0),
   // so both hazardous divisors are replaced by 1 instead of special-casing the result.
   assign w_b_zero = (i_b == '0);
   assign w_ovf    = (i_a == MIN_INT) && (&i_b);
   assign w_div_s  = (w_b_zero || w_ovf) ? ONE : i_b;
   assign w_div_u  = w_b_zero ? ONE : i_b;

   assign w_quot_s = $signed(i_a) / $signed(w_div_s);
   assign w_rem_s  = $signed(i_a) % $signed(w_div_s);
   assign w_quot_u = i_a / w_div_u;
   assign w_rem_u  = i_a % w_div_u;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch behind.
      o_res_hi   = '0;
      o_res_lo   = '0;
      o_div_zero = 1'b0;
      case (i_op)
         MD_MULT:  {o_res_hi, o_res_lo} = w_prod_s;
         MD_MULTU: {o_res_hi, o_res_lo} = w_prod_u;
         MD_DIV: begin
            o_res_hi   = w_rem_s;
            o_res_lo   = w_quot_s;
            o_div_zero = w_b_zero;
         end
         MD_DIVU: begin
            o_res_hi   = w_rem_u;
            o_res_lo   = w_quot_u;
            o_div_zero = w_b_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers, fixed-latency busy window and stall output.
// Optional macro MDU_CANCEL_EN adds the cancel input for exception flush.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
`ifdef MDU_CANCEL_EN
   input  logic             cancel,
`endif
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   output logic             busy,
   output logic             stall_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e        r_state;
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_res_hi;
   logic [WIDTH-1:0] r_res_lo;
   logic             r_div_zero;

   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_res_lo;
   logic             w_div_zero;
   logic             w_cancel;

`ifdef MDU_CANCEL_EN
   assign w_cancel = cancel;
`else
   assign w_cancel = 1'b0;
`endif

   md_calc #(.WIDTH(WIDTH)) u_calc (
      .i_op       (md_op),
      .i_a        (srcA),
      .i_b        (srcB),
      .o_res_hi   (w_res_hi),
      .o_res_lo   (w_res_lo),
      .o_div_zero (w_div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: the captured result regs are cleared too, so a reset mid-operation
      // can never let a stale result reach HI/LO later.
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_cnt      <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_res_hi   <= '0;
         r_res_lo   <= '0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && !w_cancel) begin
                  if (is_arith(md_op)) begin
                     r_res_hi   <= w_res_hi;
                     r_res_lo   <= w_res_lo;
                     r_div_zero <= w_div_zero;
                     r_cnt      <= is_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                     r_busy     <= 1'b1;
                     r_state    <= ST_BUSY;
                  end else if (md_op == MD_MTHI) begin
                     r_hi <= srcA;
                  end else if (md_op == MD_MTLO) begin
                     r_lo <= srcA;
                  end
               end
            end
            ST_BUSY: begin
               // Starts arriving here are dropped; the hazard unit keeps them away.
               if (w_cancel) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_cnt == '0) begin
                  if (!r_div_zero) begin
                     r_hi <= r_res_hi;
                     r_lo <= r_res_lo;
                  end
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign stall_req = r_busy | (start & is_arith(md_op));
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, corner sequences,
// and randomized ops checked against a 64-bit arithmetic reference model.
module tb_md_unit;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cancel = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] srcA = '0;
   logic [31:0] srcB = '0;
   logic        busy;
   logic        stall_req;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   md_unit dut (
      .clk       (clk),
      .reset     (reset),
`ifdef MDU_CANCEL_EN
      .cancel    (cancel),
`endif
      .start     (start),
      .md_op     (md_op),
      .srcA      (srcA),
      .srcB      (srcB),
      .busy      (busy),
      .stall_req (stall_req),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          n;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain 64-bit arithmetic on the operands; returns new HI/LO and busy length.
   task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                         output logic [31:0] n_hi, output logic [31:0] n_lo, output int n);
      longint      sa, sb, q, r;
      logic [63:0] p;
      n_hi = cur_hi;
      n_lo = cur_lo;
      n    = 0;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      case (op)
         3'd0: begin p = 64'(sa * sb); n_hi = p[63:32]; n_lo = p[31:0]; n = 5; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; n_hi = p[63:32]; n_lo = p[31:0]; n = 5; end
         3'd2: begin
            n = 10;
            if (b != 0) begin
               q = sa / sb; r = sa % sb;
               n_lo = q[31:0]; n_hi = r[31:0];
            end
         end
         3'd3: begin
            n = 10;
            if (b != 0) begin
               n_lo = a / b; n_hi = a % b;
            end
         end
         3'd4: n_hi = a;
         3'd5: n_lo = a;
         default: ;
      endcase
   endtask

   task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md_op = op; srcA = a; srcB = b; start = 1'b1;
      #1;
      check({name, " stall_req on start"}, stall_req, (op <= 3'd3));
      step();
      start = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_n);
      int n;
      bit held;
      issue(name, op, a, b);
      n = 0;
      held = 1'b1;
      while (busy === 1'b1 && n < 64) begin
         n++;
         if (hi !== m_hi || lo !== m_lo) held = 1'b0;
         step();
      end
      check({name, " busy cycles"}, n, exp_n);
      if (exp_n > 0) check({name, " hi/lo held while busy"}, held, 1'b1);
      check({name, " hi"}, hi, exp_hi);
      check({name, " lo"}, lo, exp_lo);
      m_hi = exp_hi;
      m_lo = exp_lo;
   endtask

   initial begin
      logic [31:0] eh, el, a, b;
      logic [2:0]  op;
      int          n;

      vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
      vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
      vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[3]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
      vecs[4]  = '{3'd4, 32'h0000_0011, 32'h0000_0000, 32'h0000_0011, 32'h8000_0000, 0};
      vecs[5]  = '{3'd5, 32'h0000_0022, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 0};
      vecs[6]  = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 10};
      vecs[7]  = '{3'd2, 32'h0000_0005, 32'h0000_0000, 32'h0000_0011, 32'h0000_0022, 10};
      vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 10};
      vecs[9]  = '{3'd6, 32'h0000_1234, 32'h0000_0001, 32'h0000_000F, 32'h0FFF_FFFF, 0};
      vecs[10] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
      vecs[11] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};

      #2;
      check("reset busy", busy, 1'b0);
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      #5 reset = 1'b1;
      step();

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n);

      // Reset pulled mid-operation: everything clears at once, result discarded.
      issue("rst_mid", 3'd0, 32'd9, 32'd9);
      step();
      reset = 1'b0;
      #1;
      check("rst_mid busy", busy, 1'b0);
      check("rst_mid hi", hi, 32'h0);
      check("rst_mid lo", lo, 32'h0);
      #2 reset = 1'b1;
      step();
      m_hi = '0; m_lo = '0;
      run_op("post_rst mult", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5);

      // Starts issued while busy are ignored; stall_req stays high throughout.
      issue("ignore mult", 3'd0, 32'd6, 32'd7);
      n = 0;
      while (busy === 1'b1 && n < 64) begin
         n++;
         start = (n == 1 || n == 2);
         md_op = (n == 1) ? 3'd5 : 3'd3;
         srcA  = (n == 1) ? 32'd5 : 32'd100;
         srcB  = 32'd3;
         #1;
         check($sformatf("ignore stall_req c%0d", n), stall_req, 1'b1);
         step();
      end
      start = 1'b0;
      check("ignore busy cycles", n, 5);
      check("ignore hi", hi, 32'd0);
      check("ignore lo", lo, 32'd42);
      step();
      check("ignore no second busy", busy, 1'b0);
      check("ignore lo kept", lo, 32'd42);
      m_hi = 32'd0; m_lo = 32'd42;

`ifdef MDU_CANCEL_EN
      issue("cancel mid", 3'd2, 32'd100, 32'd7);
      repeat (3) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("cancel mid busy", busy, 1'b0);
      check("cancel mid hi", hi, m_hi);
      check("cancel mid lo", lo, m_lo);
      issue("cancel last", 3'd2, 32'd100, 32'd7);
      repeat (9) step();
      check("cancel last still busy", busy, 1'b1);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      check("cancel last busy", busy, 1'b0);
      check("cancel last hi", hi, m_hi);
      check("cancel last lo", lo, m_lo);
      md_op = 3'd4; srcA = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
      step();
      start = 1'b0; cancel = 1'b0;
      check("cancel mthi hi", hi, m_hi);
      check("cancel mthi busy", busy, 1'b0);
`endif

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: b = '0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         ref_op(op, a, b, m_hi, m_lo, eh, el, n);
         run_op($sformatf("rand%0d op%0d", i, op), op, a, b, eh, el, n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
